// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit cacheline to DW-wide burst memory adapter
// Optional CACHELINE_ADAPTER_RADDR_CHECK_EN: drop read beats whose bmem_raddr differs from the request.
module cacheline_adapter #(
  parameter int DW = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    dfp_addr,
  input  logic           dfp_read,
  input  logic           dfp_write,
  input  logic [255:0]   dfp_wdata,
  output logic [255:0]   dfp_rdata,
  output logic           dfp_resp,
  output logic [31:0]    bmem_addr,
  output logic           bmem_read,
  output logic           bmem_write,
  output logic [DW-1:0]  bmem_wdata,
  input  logic           bmem_ready,
  input  logic [31:0]    bmem_raddr,
  input  logic [DW-1:0]  bmem_rdata,
  input  logic           bmem_rvalid
);

  localparam int BEATS = 256 / DW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BEAT,
    WR_BEAT,
    RESP
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [255:0]    wline;
  logic            last_beat;
  logic            raddr_ok;
  logic            beat_take;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  assign raddr_ok = (bmem_raddr == bmem_addr);
`else
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;
  assign raddr_ok     = 1'b1;
`endif

  assign last_beat = (cnt == CW'(BEATS - 1));
  assign beat_take = bmem_rvalid && raddr_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dfp_rdata <= '0;
      bmem_addr <= '0;
      wline     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (dfp_write || dfp_read) begin
            bmem_addr <= {dfp_addr[31:5], 5'b0};
            cnt       <= '0;
          end
          if (dfp_write) wline <= dfp_wdata;
        end
        // dfp_rdata doubles as the assembly buffer, so it keeps the last line until new beats land
        RD_BEAT: begin
          if (beat_take) begin
            dfp_rdata[int'(cnt)*DW +: DW] <= bmem_rdata;
            cnt <= cnt + CW'(1);
          end
        end
        WR_BEAT: begin
          if (bmem_ready) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (dfp_write)     state_next = WR_BEAT;
        else if (dfp_read) state_next = RD_REQ;
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) state_next = RD_BEAT;
      end
      RD_BEAT: begin
        if (beat_take && last_beat) state_next = RESP;
      end
      WR_BEAT: begin
        bmem_write = 1'b1;
        bmem_wdata = wline[int'(cnt)*DW +: DW];
        if (bmem_ready && last_beat) state_next = RESP;
      end
      RESP: begin
        dfp_resp   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - scoreboard bench for cacheline_adapter (DW=64)
module tb_cacheline_adapter;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic [31:0]   dfp_addr;
  logic          dfp_read;
  logic          dfp_write;
  logic [255:0]  dfp_wdata;
  logic [255:0]  dfp_rdata;
  logic          dfp_resp;
  logic [31:0]   bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [DW-1:0] bmem_wdata;
  logic          bmem_ready;
  logic [31:0]   bmem_raddr;
  logic [DW-1:0] bmem_rdata;
  logic          bmem_rvalid;

  cacheline_adapter #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  typedef struct {
    bit           is_read;
    logic [255:0] line;
    int           at;
  } resp_t;

  typedef struct {
    logic [31:0]   addr;
    logic [DW-1:0] data;
  } beat_t;

  resp_t       exp_resp[$];
  beat_t       exp_wbeat[$];
  logic [31:0] exp_rreq[$];
  beat_t       rd_beats[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // steps until dfp_resp is seen; optionally drops the request in that RESP cycle
  task automatic wait_resp(input bit drop);
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (dfp_resp) begin
        if (drop) begin
          dfp_read  = 1'b0;
          dfp_write = 1'b0;
        end
        return;
      end
    end
    flag("resp_timeout");
  endtask

  task automatic push_wline(input logic [31:0] addr, input logic [255:0] line);
    for (int i = 0; i < 4; i++) exp_wbeat.push_back('{addr, line[i*64 +: 64]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bmem_read"},  256'(bmem_read),  256'd0);
    check({tag, "_bmem_write"}, 256'(bmem_write), 256'd0);
    check({tag, "_dfp_resp"},   256'(dfp_resp),   256'd0);
    check({tag, "_bmem_addr"},  256'(bmem_addr),  256'd0);
    check({tag, "_bmem_wdata"}, 256'(bmem_wdata), 256'd0);
    check({tag, "_dfp_rdata"},  dfp_rdata,        256'd0);
  endtask

  // burst memory: first beat two cycles after the request handshake, then back-to-back
  beat_t mb;
  always begin
    @(negedge clk);
    if (rst === 1'b1 && bmem_read === 1'b1 && bmem_ready === 1'b1) begin
      @(posedge clk); #1;
      while (rd_beats.size() > 0) begin
        @(posedge clk); #1;
        mb = rd_beats.pop_front();
        bmem_rvalid = 1'b1;
        bmem_raddr  = mb.addr;
        bmem_rdata  = mb.data;
      end
      @(posedge clk); #1;
      bmem_rvalid = 1'b0;
    end
  end

  resp_t r;
  beat_t w;
  logic [31:0] ra;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("rd_wr_exclusive", 256'(bmem_read && bmem_write), 256'd0);
      if (dfp_resp) begin
        if (exp_resp.size() == 0) flag("unexpected_dfp_resp");
        else begin
          r = exp_resp.pop_front();
          check("resp_cycle", 256'(r.at), 256'(cyc));
          if (r.is_read) check("dfp_rdata", dfp_rdata, r.line);
        end
      end
      if (bmem_read && bmem_ready) begin
        if (exp_rreq.size() == 0) flag("unexpected_read_request");
        else begin
          ra = exp_rreq.pop_front();
          check("rreq_addr", 256'(bmem_addr), 256'(ra));
        end
      end
      if (bmem_write) begin
        if (exp_wbeat.size() == 0) flag("unexpected_write_beat");
        else if (bmem_ready) begin
          w = exp_wbeat.pop_front();
          check("wbeat_addr", 256'(bmem_addr), 256'(w.addr));
          check("wbeat_data", 256'(bmem_wdata), 256'(w.data));
        end else begin
          check("wbeat_stall_data", 256'(bmem_wdata), 256'(exp_wbeat[0].data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int c;
  initial begin
    rst = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    step(3);
    check_all_zero("reset");
    rst = 1'b1;
    step(1);

    // basic read, unaligned address
    rd_beats.push_back('{32'h0000_1220, 64'h1111_1111_1111_1111});
    rd_beats.push_back('{32'h0000_1220, 64'h2222_2222_2222_2222});
    rd_beats.push_back('{32'h0000_1220, 64'h3333_3333_3333_3333});
    rd_beats.push_back('{32'h0000_1220, 64'h4444_4444_4444_4444});
    c = cyc;
    dfp_addr = 32'h0000_1234; dfp_read = 1'b1;
    exp_rreq.push_back(32'h0000_1220);
    exp_resp.push_back('{1'b1, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, c + 7});
    wait_resp(1'b1);
    step(3);

    // write with ready low for 3 cycles on beat 2
    c = cyc;
    dfp_addr = 32'h8000_0040; dfp_write = 1'b1;
    dfp_wdata = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF};
    exp_wbeat.push_back('{32'h8000_0040, 64'h8899_AABB_CCDD_EEFF});
    exp_wbeat.push_back('{32'h8000_0040, 64'h0011_2233_4455_6677});
    exp_wbeat.push_back('{32'h8000_0040, 64'hFEDC_BA98_7654_3210});
    exp_wbeat.push_back('{32'h8000_0040, 64'h0123_4567_89AB_CDEF});
    exp_resp.push_back('{1'b0, 256'd0, c + 8});
    step(3);
    bmem_ready = 1'b0;
    step(3);
    bmem_ready = 1'b1;
    wait_resp(1'b1);
    step(3);

    // writeback then allocate: read held through the write's RESP
    c = cyc;
    dfp_addr = 32'h0000_0100; dfp_write = 1'b1;
    dfp_wdata = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    push_wline(32'h0000_0100, dfp_wdata);
    exp_resp.push_back('{1'b0, 256'd0, c + 5});
    rd_beats.push_back('{32'h0000_0200, 64'hB0B0_B0B0_B0B0_B0B0});
    rd_beats.push_back('{32'h0000_0200, 64'hB1B1_B1B1_B1B1_B1B1});
    rd_beats.push_back('{32'h0000_0200, 64'hB2B2_B2B2_B2B2_B2B2});
    rd_beats.push_back('{32'h0000_0200, 64'hB3B3_B3B3_B3B3_B3B3});
    exp_rreq.push_back(32'h0000_0200);
    exp_resp.push_back('{1'b1, {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                                64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0}, c + 13});
    step(2);
    dfp_write = 1'b0; dfp_read = 1'b1; dfp_addr = 32'h0000_0210;
    wait_resp(1'b0);
    wait_resp(1'b1);
    step(3);

    // flush: read dropped after beat 1, address scrambled
    rd_beats.push_back('{32'h0000_4000, 64'hC0C0_C0C0_C0C0_C0C0});
    rd_beats.push_back('{32'h0000_4000, 64'hC1C1_C1C1_C1C1_C1C1});
    rd_beats.push_back('{32'h0000_4000, 64'hC2C2_C2C2_C2C2_C2C2});
    rd_beats.push_back('{32'h0000_4000, 64'hC3C3_C3C3_C3C3_C3C3});
    c = cyc;
    dfp_addr = 32'h0000_4008; dfp_read = 1'b1;
    exp_rreq.push_back(32'h0000_4000);
    exp_resp.push_back('{1'b1, {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                                64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0}, c + 7});
    step(5);
    dfp_read = 1'b0; dfp_addr = 32'hFFFF_FFFF;
    wait_resp(1'b1);
    step(5);

    // foreign-address beat inserted as the second beat
    rd_beats.push_back('{32'h0000_0600, 64'hD0D0_D0D0_D0D0_D0D0});
    rd_beats.push_back('{32'hDEAD_0000, 64'hDEAD_DEAD_DEAD_DEAD});
    rd_beats.push_back('{32'h0000_0600, 64'hD1D1_D1D1_D1D1_D1D1});
    rd_beats.push_back('{32'h0000_0600, 64'hD2D2_D2D2_D2D2_D2D2});
    rd_beats.push_back('{32'h0000_0600, 64'hD3D3_D3D3_D3D3_D3D3});
    c = cyc;
    dfp_addr = 32'h0000_0600; dfp_read = 1'b1;
    exp_rreq.push_back(32'h0000_0600);
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    exp_resp.push_back('{1'b1, {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                                64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0}, c + 8});
`else
    exp_resp.push_back('{1'b1, {64'hD2D2_D2D2_D2D2_D2D2, 64'hD1D1_D1D1_D1D1_D1D1,
                                64'hDEAD_DEAD_DEAD_DEAD, 64'hD0D0_D0D0_D0D0_D0D0}, c + 7});
`endif
    wait_resp(1'b1);
    step(4);

    // reset in RD_BEAT with cnt=2; remaining beats arrive stale
    rd_beats.push_back('{32'h0000_0800, 64'hE0E0_E0E0_E0E0_E0E0});
    rd_beats.push_back('{32'h0000_0800, 64'hE1E1_E1E1_E1E1_E1E1});
    rd_beats.push_back('{32'h0000_0800, 64'hE2E2_E2E2_E2E2_E2E2});
    rd_beats.push_back('{32'h0000_0800, 64'hE3E3_E3E3_E3E3_E3E3});
    dfp_addr = 32'h0000_0800; dfp_read = 1'b1;
    exp_rreq.push_back(32'h0000_0800);
    step(5);
    rst = 1'b0; dfp_read = 1'b0;
    step(1);
    check_all_zero("midburst_reset");
    rst = 1'b1;
    step(4);

    // normal read after the aborted one
    rd_beats.push_back('{32'h0000_0A00, 64'hF0F0_F0F0_F0F0_F0F0});
    rd_beats.push_back('{32'h0000_0A00, 64'hF1F1_F1F1_F1F1_F1F1});
    rd_beats.push_back('{32'h0000_0A00, 64'hF2F2_F2F2_F2F2_F2F2});
    rd_beats.push_back('{32'h0000_0A00, 64'hF3F3_F3F3_F3F3_F3F3});
    c = cyc;
    dfp_addr = 32'h0000_0A1C; dfp_read = 1'b1;
    exp_rreq.push_back(32'h0000_0A00);
    exp_resp.push_back('{1'b1, {64'hF3F3_F3F3_F3F3_F3F3, 64'hF2F2_F2F2_F2F2_F2F2,
                                64'hF1F1_F1F1_F1F1_F1F1, 64'hF0F0_F0F0_F0F0_F0F0}, c + 7});
    wait_resp(1'b1);
    step(5);

    check("left_resp",  256'(exp_resp.size()),  256'd0);
    check("left_wbeat", 256'(exp_wbeat.size()), 256'd0);
    check("left_rreq",  256'(exp_rreq.size()),  256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
